// File: rtl/sd_init_seq_if.sv
// sd_init_seq_if
//   This is the command bus between the SD initialization sequencer (master)
//   and the single-command SPI engine (slave).
//   cmd_number    : command byte including the start/transmit bits (0x40|index)
//   cmd_args      : 32-bit command argument
//   cmd_crc       : CRC7 plus the end bit
//   cmd_start     : level signal; the engine runs while it is high and clears while it is low
//   cmd_done      : the engine has finished the command or has timed out
//   cmd_response  : R1 byte, bit-reversed (bit 0 is the first bit on the wire)
//   cmd_resp_seen : pulses while R1 bits are being received
interface sd_init_seq_if;
   logic [7:0]  cmd_number;
   logic [31:0] cmd_args;
   logic [7:0]  cmd_crc;
   logic        cmd_start;
   logic        cmd_done;
   logic [7:0]  cmd_response;
   logic        cmd_resp_seen;

   modport master (
      output cmd_number, cmd_args, cmd_crc, cmd_start,
      input  cmd_done, cmd_response, cmd_resp_seen
   );

   modport slave (
      input  cmd_number, cmd_args, cmd_crc, cmd_start,
      output cmd_done, cmd_response, cmd_resp_seen
   );
endinterface

// File: rtl/sd_init_seq.sv
// sd_init_seq
//   SPI-mode SD card initialization sequencer. After init_start it holds
//   chip-select high through the power-up clock window. It then issues
//   CMD0 -> CMD8 -> (CMD55 -> ACMD41)* through the command engine and
//   reports ready, the card version, or a coded failure.
//   Optional feature macro: SD_INIT_CMD8_EN. When it is defined, CMD8 is
//   issued and card_v2/HCS come from the CMD8 response. When it is undefined,
//   CMD0 goes straight to CMD55, card_v2 stays 0 and the ACMD41 argument is 0.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   init_start   : single-cycle pulse; starts or restarts the sequence from any state
//   cmd          : command bus to the engine (sd_init_seq_if.master)
//   cs_n         : card chip select, active low
//   init_done    : card initialized (sticky)
//   init_error   : sequence failed (sticky)
//   error_code   : 0 none, 1 CMD0 bad R1, 2 CMD8 bad R1, 3 ACMD41 retries
//                  exhausted, 4 no response, 5 CMD55/ACMD41 error bits set
//   card_v2      : card accepted CMD8 (SD v2+)
//   retry_count  : ACMD41 attempts made so far
module sd_init_seq #(
   parameter int POWERUP_CLKS   = 80,
   parameter int GAP_CLKS       = 16,
   parameter int ACMD41_RETRIES = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init_start,
   sd_init_seq_if.master cmd,
   output logic          cs_n,
   output logic          init_done,
   output logic          init_error,
   output logic [2:0]    error_code,
   output logic          card_v2,
   output logic [7:0]    retry_count
);

   typedef enum logic [2:0] {IDLE, PWRUP, ISSUE, GAP, READY, FAIL} state_t;
   typedef enum logic [2:0] {C0, C8, C55, C41} sel_t;

   // R1 values as delivered by the engine, which bit-reverses the byte:
   // wire 0x01 (idle) = 0x80, wire 0x00 = 0x00, wire 0x05 (illegal cmd) = 0xA0
   localparam logic [7:0] R1_IDLE    = 8'h80;
   localparam logic [7:0] R1_OK      = 8'h00;
   localparam logic [7:0] R1_ILLEGAL = 8'hA0;

   state_t      state;
   sel_t        sel;
   logic [15:0] cnt;
   logic        seen_flag;
   logic [7:0]  number_q;
   logic [31:0] args_q;
   logic [7:0]  crc_q;
   logic        start_q;

   logic        seen_any;
   logic        dec_fail;
   logic        dec_ready;
   logic [2:0]  dec_code;
   sel_t        dec_next;
   logic        dec_v2;
   logic [7:0]  dec_retry;
   logic [7:0]  retry_inc;

   assign cmd.cmd_number = number_q;
   assign cmd.cmd_args   = args_q;
   assign cmd.cmd_crc    = crc_q;
   assign cmd.cmd_start  = start_q;

   // Encodes each command as {number, argument, crc}.
   function automatic logic [47:0] cmd_fields(input sel_t s, input logic v2);
      case (s)
         C0:      cmd_fields = {8'h40, 32'h0000_0000, 8'h95};
         C8:      cmd_fields = {8'h48, 32'h0000_01AA, 8'h87};
         C55:     cmd_fields = {8'h77, 32'h0000_0000, 8'h01};
         C41:     cmd_fields = {8'h69, (v2 ? 32'h4000_0000 : 32'h0000_0000), 8'h01};
         default: cmd_fields = 48'h0;
      endcase
   endfunction

   // A response pulse in the same cycle as cmd_done still counts as a response.
   assign seen_any  = seen_flag | cmd.cmd_resp_seen;
   assign retry_inc = (retry_count == 8'hFF) ? 8'hFF : retry_count + 8'd1;

   // This block decodes the response to the current command. The result is
   // only used in the cycle where cmd_done is sampled in ISSUE.
   always_comb begin
      dec_fail  = 1'b0;
      dec_ready = 1'b0;
      dec_code  = 3'd0;
      dec_next  = sel;
      dec_retry = retry_count;
`ifdef SD_INIT_CMD8_EN
      dec_v2    = card_v2;
`else
      dec_v2    = 1'b0;
`endif
      if (!seen_any) begin
         dec_fail = 1'b1;
         dec_code = 3'd4;
      end else begin
         case (sel)
            C0: begin
               if (cmd.cmd_response == R1_IDLE) begin
`ifdef SD_INIT_CMD8_EN
                  dec_next = C8;
`else
                  dec_next = C55;
`endif
               end else begin
                  dec_fail = 1'b1;
                  dec_code = 3'd1;
               end
            end
`ifdef SD_INIT_CMD8_EN
            C8: begin
               if (cmd.cmd_response == R1_IDLE) begin
                  dec_v2   = 1'b1;
                  dec_next = C55;
               end else if (cmd.cmd_response == R1_ILLEGAL) begin
                  dec_v2   = 1'b0;
                  dec_next = C55;
               end else begin
                  dec_fail = 1'b1;
                  dec_code = 3'd2;
               end
            end
`endif
            C55: begin
               if (cmd.cmd_response == R1_IDLE || cmd.cmd_response == R1_OK) begin
                  dec_next = C41;
               end else begin
                  dec_fail = 1'b1;
                  dec_code = 3'd5;
               end
            end
            C41: begin
               if (cmd.cmd_response == R1_OK) begin
                  dec_ready = 1'b1;
               end else if (cmd.cmd_response == R1_IDLE) begin
                  dec_retry = retry_inc;
                  if (retry_inc >= 8'(ACMD41_RETRIES)) begin
                     dec_fail = 1'b1;
                     dec_code = 3'd3;
                  end else begin
                     dec_next = C55;
                  end
               end else begin
                  dec_fail = 1'b1;
                  dec_code = 3'd5;
               end
            end
            default: begin
               // This selector is never issued in this build.
               dec_fail = 1'b1;
               dec_code = 3'd4;
            end
         endcase
      end
   end

   // This is the sequencer FSM. Command fields are loaded when GAP is entered,
   // so they are stable for the whole gap and for the whole ISSUE that follows.
   // cs_n is driven low only on the first ISSUE. The gap right after power-up
   // therefore still has the card deselected, as an extension of the dummy
   // clock window.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         sel         <= C0;
         cnt         <= '0;
         seen_flag   <= 1'b0;
         number_q    <= '0;
         args_q      <= '0;
         crc_q       <= '0;
         start_q     <= 1'b0;
         cs_n        <= 1'b1;
         init_done   <= 1'b0;
         init_error  <= 1'b0;
         error_code  <= '0;
         card_v2     <= 1'b0;
         retry_count <= '0;
      end else if (init_start) begin
         state       <= PWRUP;
         cnt         <= '0;
         seen_flag   <= 1'b0;
         start_q     <= 1'b0;
         cs_n        <= 1'b1;
         init_done   <= 1'b0;
         init_error  <= 1'b0;
         error_code  <= '0;
         card_v2     <= 1'b0;
         retry_count <= '0;
      end else begin
         case (state)
            PWRUP: begin
               if (cnt == 16'(POWERUP_CLKS - 1)) begin
                  state <= GAP;
                  cnt   <= '0;
                  sel   <= C0;
                  {number_q, args_q, crc_q} <= cmd_fields(C0, 1'b0);
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            GAP: begin
               if (cnt == 16'(GAP_CLKS - 1)) begin
                  state     <= ISSUE;
                  cnt       <= '0;
                  seen_flag <= 1'b0;
                  start_q   <= 1'b1;
                  cs_n      <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ISSUE: begin
               if (cmd.cmd_done) begin
                  start_q     <= 1'b0;
                  cnt         <= '0;
                  retry_count <= dec_retry;
                  if (dec_fail) begin
                     state      <= FAIL;
                     error_code <= dec_code;
                     init_error <= 1'b1;
                     cs_n       <= 1'b1;
                  end else if (dec_ready) begin
                     state     <= READY;
                     init_done <= 1'b1;
                     cs_n      <= 1'b1;
                  end else begin
                     state   <= GAP;
                     sel     <= dec_next;
                     card_v2 <= dec_v2;
                     {number_q, args_q, crc_q} <= cmd_fields(dec_next, dec_v2);
                  end
               end else begin
                  seen_flag <= seen_any;
               end
            end
            default: begin
               // IDLE, READY and FAIL hold until init_start or reset.
            end
         endcase
      end
   end

endmodule
